cpu_decode: RTL and testbench
=============================

# cpu_decode

Instruction decode stage of the moxie pipeline, directly downstream of `cpu_fetch`. It consumes `opcode`/`operand`/`valid` from the fetch instruction FIFO and splits each 16-bit moxie instruction into form, opcode and register/immediate fields. It tracks outstanding loads in a 16-entry register scoreboard and holds issue while a source register is still pending (load-use interlock). It presents one registered decoded instruction per cycle to execute, and back-pressures fetch through `stall_o`.

## Interface
- No parameters; widths are fixed by the moxie ISA (16 GPRs, 16-bit opcode word, 32-bit operand).
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `opcode_i` in 16: instruction word from fetch.
- `operand_i` in 32: 32-bit immediate word accompanying `opcode_i`.
- `valid_i` in 1: `opcode_i`/`operand_i` hold an instruction.
- `stall_o` out 1: to fetch `stall_i`; 1 means the current input is not consumed this cycle.
- `flush_i` in 1: branch taken; discard the decode output register.
- `stall_i` in 1: execute cannot accept; hold the output register.
- `wb_valid_i` in 1: load writeback completes this cycle.
- `wb_reg_i` in 4: destination register of the completing load.
- `valid_o` out 1: decoded instruction valid.
- `form_o` out 2: 0 = form1, 2 = form2, 3 = form3.
- `op_o` out 8: opcode. Form1 gives bits 15:8. Form2 gives {6'b0, bits 13:12}. Form3 gives {4'b0, bits 13:10}.
- `ra_o`, `rb_o` out 4 each: register fields.
- `imm_o` out 32: form1 gives `operand_i`; form2 gives zero-extended bits 7:0; form3 gives {{21{b9}}, bits 9:0, 1'b0}.
- `is_load_o` out 1: instruction is a load (definition below).
- `hazard_cnt_o` out 16: saturating count of interlock bubbles.

## Operation
- Field split:
  - Form1 (bit15=0): ra=bits 7:4, rb=bits 3:0.
  - Form2 (bits 15:14=10): ra=bits 11:8, rb=0.
  - Form3 (bits 15:14=11): ra=rb=0.
- Source reads:
  - Form1 reads ra and rb, except op 0x01 (ldi.l), which reads nothing.
  - Form2 reads ra.
  - Form3 reads nothing.
- Loads are form1 ops 0x08, 0x0a, 0x0c, 0x1c, 0x1d, 0x21, 0x22, 0x36, 0x38. The destination is ra.
- Scoreboard: `busy[15:0]`.
  - On issue of a load, set `busy[ra]`.
  - When `wb_valid_i`=1, clear `busy[wb_reg_i]`.
  - If a set and a clear hit the same register in the same cycle, the set wins.
- Hazard (combinational) = `valid_i` and some read register r has `busy[r]`=1, and not (`wb_valid_i` with `wb_reg_i`=r). A same-cycle writeback bypasses the interlock.
- Output register advance condition: `adv` = !`stall_i` or !`valid_o`.
- Issue = `valid_i` & `adv` & !hazard & !`flush_i`. On issue, all output fields load and `valid_o`<=1.
- When `adv` holds and there is no issue, `valid_o`<=0 (bubble). The field outputs may hold stale values while `valid_o`=0.
- `stall_o` = `valid_i` & !issue. `stall_o`=0 when `valid_i`=0.
- `flush_i`=1 forces `valid_o`<=0 regardless of `stall_i`. The input is not consumed. `busy` is unchanged, because in-flight loads still write back.
- `hazard_cnt_o` increments when `valid_i` & `adv` & hazard & !`flush_i`. It saturates at 0xFFFF.

## Timing
- Reset values: `valid_o`=0, all fields 0, `busy`=0, `hazard_cnt_o`=0. `stall_o` is combinational and is 0 during reset.
- Reset mid-operation asynchronously clears `busy` and drops any held instruction.
- Latency: input accepted at edge N appears on the outputs after edge N, giving one cycle of latency.
- Throughput: one instruction per cycle when there is no hazard and no stall.
- While `stall_i`=1 and `valid_o`=1, all outputs are held stable and `stall_o`=1 for any valid input.
- A load-use pair with writeback k cycles after load issue produces k-1 bubbles. Writeback in the cycle of the dependent instruction's decode produces 0 extra bubbles (bypass).
- Simultaneous flush, stall_i and writeback: the flush clears `valid_o` and the writeback clear still applies.

## Test plan
- Reset, then stream 0x2634 (form1 op 0x26, ra=3, rb=4), 0x8A05 and 0xC3FF with `stall_i`=0. Required response: consecutive cycles show form 0/2/3; op 0x26/0x00/0x00; ra 3/10/0; imm `operand_i`/0x5/0xFFFFFFFE; `stall_o`=0 throughout.
- Issue load 0x0A21 (ld.l r2,(r1)), then 0x0525 (reads r2) with no writeback. Required response: `stall_o`=1 and `valid_o`=0 each following cycle, `hazard_cnt_o` increments per cycle. Pulse `wb_valid_i` with `wb_reg_i`=2: 0x0525 issues in that same cycle.
- With `busy[5]` set, pulse `wb_valid_i`/`wb_reg_i`=5 while a new load to r5 issues. Required response: `busy[5]` stays 1 and a subsequent reader of r5 stalls.
- Hold `stall_i`=1 for 3 cycles with `valid_o`=1. Required response: outputs unchanged, `stall_o`=1, no input consumed, and on release the next instruction follows without loss.
- Assert `flush_i` with `valid_o`=1 and `stall_i`=1. Required response: `valid_o`=0 next cycle and a pending `busy` bit is retained.
- Force 70000 hazard cycles. Required response: `hazard_cnt_o`=0xFFFF and holds there. Assert `rst_i`=0 mid-stall: all outputs return to zero immediately.

Source files
------------

// File: rtl/cpu_decode.sv
// cpu_decode: moxie instruction decode stage.
// Splits each 16-bit instruction word into form/opcode/register/immediate
// fields and presents one registered decoded instruction per cycle. A
// 16-entry scoreboard tracks outstanding loads. Issue is held while a source
// register still waits on a load (load-use interlock). A writeback landing in
// the same cycle bypasses the interlock.
module cpu_decode (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] opcode_i,
    input  logic [31:0] operand_i,
    input  logic        valid_i,
    output logic        stall_o,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        wb_valid_i,
    input  logic [3:0]  wb_reg_i,
    output logic        valid_o,
    output logic [1:0]  form_o,
    output logic [7:0]  op_o,
    output logic [3:0]  ra_o,
    output logic [3:0]  rb_o,
    output logic [31:0] imm_o,
    output logic        is_load_o,
    output logic [15:0] hazard_cnt_o
);

    logic [1:0]  form_s;
    logic [7:0]  op_s;
    logic [3:0]  ra_s;
    logic [3:0]  rb_s;
    logic [31:0] imm_s;
    logic        reads_ra_s;
    logic        reads_rb_s;
    logic        is_load_s;
    logic        hazard_s;
    logic        adv_s;
    logic        issue_s;
    logic [15:0] busy_r;
    logic [15:0] busy_nxt_s;

    // A register is still pending unless this cycle's writeback frees it.
    function automatic logic reg_pending(input logic [15:0] busy,
                                         input logic        wbv,
                                         input logic [3:0]  wbr,
                                         input logic [3:0]  r);
        return busy[r] & ~(wbv & (wbr == r));
    endfunction

    // Field split and source-register usage for the incoming instruction.
    always_comb begin
        form_s     = 2'd0;
        op_s       = 8'h00;
        ra_s       = 4'h0;
        rb_s       = 4'h0;
        imm_s      = 32'h0000_0000;
        reads_ra_s = 1'b0;
        reads_rb_s = 1'b0;
        case (opcode_i[15:14])
            2'b10: begin
                form_s     = 2'd2;
                op_s       = {6'b00_0000, opcode_i[13:12]};
                ra_s       = opcode_i[11:8];
                imm_s      = {24'h00_0000, opcode_i[7:0]};
                reads_ra_s = 1'b1;
            end
            2'b11: begin
                form_s = 2'd3;
                op_s   = {4'h0, opcode_i[13:10]};
                imm_s  = {{21{opcode_i[9]}}, opcode_i[9:0], 1'b0};
            end
            default: begin
                // Form1: ldi.l (0x01) takes its value from the operand word only.
                form_s     = 2'd0;
                op_s       = opcode_i[15:8];
                ra_s       = opcode_i[7:4];
                rb_s       = opcode_i[3:0];
                imm_s      = operand_i;
                reads_ra_s = (opcode_i[15:8] != 8'h01);
                reads_rb_s = (opcode_i[15:8] != 8'h01);
            end
        endcase
    end

    // Load classification: only form1 opcodes can be loads.
    always_comb begin
        is_load_s = 1'b0;
        if (form_s == 2'd0) begin
            case (op_s)
                8'h08, 8'h0a, 8'h0c, 8'h1c, 8'h1d,
                8'h21, 8'h22, 8'h36, 8'h38: is_load_s = 1'b1;
                default:                    is_load_s = 1'b0;
            endcase
        end else begin
            is_load_s = 1'b0;
        end
    end

    assign hazard_s = valid_i &
                      ((reads_ra_s & reg_pending(busy_r, wb_valid_i, wb_reg_i, ra_s)) |
                       (reads_rb_s & reg_pending(busy_r, wb_valid_i, wb_reg_i, rb_s)));
    assign adv_s    = ~stall_i | ~valid_o;
    assign issue_s  = valid_i & adv_s & ~hazard_s & ~flush_i;
    assign stall_o  = valid_i & ~issue_s;

    // Next scoreboard: writeback clears, issuing load sets, set wins on a tie.
    always_comb begin
        busy_nxt_s = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            busy_nxt_s[i] = (busy_r[i] & ~(wb_valid_i & (wb_reg_i == i[3:0]))) |
                            (issue_s & is_load_s & (ra_s == i[3:0]));
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_r <= 16'h0000;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Decoded-instruction output register: load on issue, bubble otherwise, hold on stall.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o   <= 1'b0;
            form_o    <= 2'd0;
            op_o      <= 8'h00;
            ra_o      <= 4'h0;
            rb_o      <= 4'h0;
            imm_o     <= 32'h0000_0000;
            is_load_o <= 1'b0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (adv_s) begin
            valid_o <= issue_s;
            if (issue_s) begin
                form_o    <= form_s;
                op_o      <= op_s;
                ra_o      <= ra_s;
                rb_o      <= rb_s;
                imm_o     <= imm_s;
                is_load_o <= is_load_s;
            end
        end
    end

    // Saturating count of interlock bubbles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hazard_cnt_o <= 16'h0000;
        end else if (valid_i && adv_s && hazard_s && !flush_i &&
                     (hazard_cnt_o != 16'hFFFF)) begin
            hazard_cnt_o <= hazard_cnt_o + 16'h0001;
        end
    end

endmodule

// File: tb/tb_cpu_decode.sv
// Directed testbench for cpu_decode with hand-computed expected values.
module tb_cpu_decode;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] opcode_i;
    logic [31:0] operand_i;
    logic        valid_i;
    logic        stall_o;
    logic        flush_i;
    logic        stall_i;
    logic        wb_valid_i;
    logic [3:0]  wb_reg_i;
    logic        valid_o;
    logic [1:0]  form_o;
    logic [7:0]  op_o;
    logic [3:0]  ra_o;
    logic [3:0]  rb_o;
    logic [31:0] imm_o;
    logic        is_load_o;
    logic [15:0] hazard_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    cpu_decode dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .opcode_i     (opcode_i),
        .operand_i    (operand_i),
        .valid_i      (valid_i),
        .stall_o      (stall_o),
        .flush_i      (flush_i),
        .stall_i      (stall_i),
        .wb_valid_i   (wb_valid_i),
        .wb_reg_i     (wb_reg_i),
        .valid_o      (valid_o),
        .form_o       (form_o),
        .op_o         (op_o),
        .ra_o         (ra_o),
        .rb_o         (rb_o),
        .imm_o        (imm_o),
        .is_load_o    (is_load_o),
        .hazard_cnt_o (hazard_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic put(input logic [15:0] opc, input logic [31:0] opr, input logic v);
        opcode_i  = opc;
        operand_i = opr;
        valid_i   = v;
        #2;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] f,
                           input logic [7:0] op, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [31:0] imm, input logic ld);
        chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
        chk({tag, ".form"},  {30'd0, form_o},  {30'd0, f});
        chk({tag, ".op"},    {24'd0, op_o},    {24'd0, op});
        chk({tag, ".ra"},    {28'd0, ra_o},    {28'd0, ra});
        chk({tag, ".rb"},    {28'd0, rb_o},    {28'd0, rb});
        chk({tag, ".imm"},   imm_o,            imm);
        chk({tag, ".load"},  {31'd0, is_load_o}, {31'd0, ld});
    endtask

    initial begin
        rst_i      = 1'b0;
        opcode_i   = 16'h0000;
        operand_i  = 32'h0000_0000;
        valid_i    = 1'b0;
        flush_i    = 1'b0;
        stall_i    = 1'b0;
        wb_valid_i = 1'b0;
        wb_reg_i   = 4'h0;

        // Reset state
        tick(); tick();
        chk_out("reset", 1'b0, 2'd0, 8'h00, 4'h0, 4'h0, 32'h0, 1'b0);
        chk("reset.cnt",   {16'd0, hazard_cnt_o}, 32'h0);
        chk("reset.stall", {31'd0, stall_o}, 32'h0);
        rst_i = 1'b1;
        tick();

        // Stream of form1 / form2 / form3 instructions
        put(16'h2634, 32'h1234_5678, 1'b1);
        chk("s1.stall", {31'd0, stall_o}, 32'h0);
        tick();
        chk_out("s1", 1'b1, 2'd0, 8'h26, 4'h3, 4'h4, 32'h1234_5678, 1'b0);
        put(16'h8A05, 32'hDEAD_BEEF, 1'b1);
        chk("s2.stall", {31'd0, stall_o}, 32'h0);
        tick();
        chk_out("s2", 1'b1, 2'd2, 8'h00, 4'hA, 4'h0, 32'h0000_0005, 1'b0);
        put(16'hC3FF, 32'hDEAD_BEEF, 1'b1);
        chk("s3.stall", {31'd0, stall_o}, 32'h0);
        tick();
        chk_out("s3", 1'b1, 2'd3, 8'h00, 4'h0, 4'h0, 32'hFFFF_FFFE, 1'b0);
        put(16'hB7F0, 32'h0, 1'b1);
        tick();
        chk_out("s4", 1'b1, 2'd2, 8'h03, 4'h7, 4'h0, 32'h0000_00F0, 1'b0);
        put(16'hE555, 32'h0, 1'b1);
        tick();
        chk_out("s5", 1'b1, 2'd3, 8'h09, 4'h0, 4'h0, 32'h0000_02AA, 1'b0);

        // Load-use interlock: ld.l r2,(r1) then a reader of r2
        put(16'h0A21, 32'h0, 1'b1);
        chk("lu.ld.stall", {31'd0, stall_o}, 32'h0);
        tick();
        chk_out("lu.ld", 1'b1, 2'd0, 8'h0A, 4'h2, 4'h1, 32'h0, 1'b1);
        put(16'h0525, 32'h0, 1'b1);
        chk("lu.stall0", {31'd0, stall_o}, 32'h1);
        tick();
        chk("lu.valid1", {31'd0, valid_o}, 32'h0);
        chk("lu.cnt1", {16'd0, hazard_cnt_o}, 32'd1);
        chk("lu.stall1", {31'd0, stall_o}, 32'h1);
        tick();
        chk("lu.valid2", {31'd0, valid_o}, 32'h0);
        chk("lu.cnt2", {16'd0, hazard_cnt_o}, 32'd2);
        wb_valid_i = 1'b1; wb_reg_i = 4'h2; #1;
        chk("lu.bypass.stall", {31'd0, stall_o}, 32'h0);
        tick();
        wb_valid_i = 1'b0;
        chk_out("lu.use", 1'b1, 2'd0, 8'h05, 4'h2, 4'h5, 32'h0, 1'b0);
        chk("lu.cnt3", {16'd0, hazard_cnt_o}, 32'd2);

        // Set beats clear on r5
        put(16'h0856, 32'h0, 1'b1);
        tick();
        chk("sc.ld1.load", {31'd0, is_load_o}, 32'h1);
        wb_valid_i = 1'b1; wb_reg_i = 4'h5;
        put(16'h0C54, 32'h0, 1'b1);
        chk("sc.ld2.stall", {31'd0, stall_o}, 32'h0);
        tick();
        wb_valid_i = 1'b0;
        chk_out("sc.ld2", 1'b1, 2'd0, 8'h0C, 4'h5, 4'h4, 32'h0, 1'b1);
        put(16'h0250, 32'h0, 1'b1);
        chk("sc.rd.stall", {31'd0, stall_o}, 32'h1);
        tick();
        chk("sc.rd.valid", {31'd0, valid_o}, 32'h0);
        chk("sc.rd.cnt", {16'd0, hazard_cnt_o}, 32'd3);
        wb_valid_i = 1'b1; wb_reg_i = 4'h5;
        tick();
        wb_valid_i = 1'b0;
        chk_out("sc.rd", 1'b1, 2'd0, 8'h02, 4'h5, 4'h0, 32'h0, 1'b0);

        // Downstream stall holds the output register
        stall_i = 1'b1;
        put(16'h1123, 32'h0, 1'b1);
        chk("hold.stall0", {31'd0, stall_o}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("hold", 1'b1, 2'd0, 8'h02, 4'h5, 4'h0, 32'h0, 1'b0);
            chk("hold.stall", {31'd0, stall_o}, 32'h1);
        end
        stall_i = 1'b0; #1;
        chk("hold.rel.stall", {31'd0, stall_o}, 32'h0);
        tick();
        chk_out("hold.next", 1'b1, 2'd0, 8'h11, 4'h2, 4'h3, 32'h0, 1'b0);
        put(16'h0000, 32'h0, 1'b0);
        tick();
        chk("idle.valid", {31'd0, valid_o}, 32'h0);

        // Flush with stall and an unrelated writeback; busy[7] must survive
        put(16'h0A70, 32'h0, 1'b1);
        tick();
        chk("fl.ld.valid", {31'd0, valid_o}, 32'h1);
        stall_i = 1'b1; flush_i = 1'b1; wb_valid_i = 1'b1; wb_reg_i = 4'h3;
        put(16'h0175, 32'h0, 1'b1);
        chk("fl.stall", {31'd0, stall_o}, 32'h1);
        tick();
        stall_i = 1'b0; flush_i = 1'b0; wb_valid_i = 1'b0;
        chk("fl.valid", {31'd0, valid_o}, 32'h0);
        put(16'h0370, 32'h0, 1'b1);
        chk("fl.busy.stall", {31'd0, stall_o}, 32'h1);
        tick();
        chk("fl.cnt", {16'd0, hazard_cnt_o}, 32'd4);
        // ldi.l reads nothing, so r7 busy does not block it
        put(16'h0170, 32'hCAFE_0001, 1'b1);
        chk("ldi.stall", {31'd0, stall_o}, 32'h0);
        tick();
        chk_out("ldi", 1'b1, 2'd0, 8'h01, 4'h7, 4'h0, 32'hCAFE_0001, 1'b0);

        // Saturating hazard counter
        put(16'h0370, 32'h0, 1'b1);
        for (int k = 0; k < 65530; k++) tick();
        chk("sat.pre", {16'd0, hazard_cnt_o}, 32'h0000_FFFE);
        tick();
        chk("sat.hit", {16'd0, hazard_cnt_o}, 32'h0000_FFFF);
        for (int k = 0; k < 4469; k++) tick();
        chk("sat.hold", {16'd0, hazard_cnt_o}, 32'h0000_FFFF);

        // Asynchronous reset mid-stall
        put(16'h0170, 32'h5555_AAAA, 1'b1);
        tick();
        stall_i = 1'b1;
        put(16'h0370, 32'h0, 1'b1);
        chk("rs.pre.valid", {31'd0, valid_o}, 32'h1);
        chk("rs.pre.stall", {31'd0, stall_o}, 32'h1);
        rst_i = 1'b0; #1;
        chk_out("rs", 1'b0, 2'd0, 8'h00, 4'h0, 4'h0, 32'h0, 1'b0);
        chk("rs.cnt", {16'd0, hazard_cnt_o}, 32'h0);
        chk("rs.stall", {31'd0, stall_o}, 32'h0);
        tick();
        rst_i = 1'b1; stall_i = 1'b0; #1;
        chk("rs.busy.stall", {31'd0, stall_o}, 32'h0);
        tick();
        chk_out("rs.after", 1'b1, 2'd0, 8'h03, 4'h7, 4'h0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
